xrv_imem_resp: RTL and testbench
================================

# xrv_imem_resp

Instruction-memory responder for the xriscv core: the far end of the fetch unit's `i_addr`/`i_data` interface. It holds program words in a single-port word array and returns the word addressed by `i_addr` one cycle later. After reset it first accepts a program image through a valid/ready loader port, for example from a boot loader or debug bridge. Once the image is complete it switches to serving fetches and raises `boot_done`, which gates the core's release.

## Interface
- `DEPTH_WORDS`, default 4096: array depth in 32-bit words; must be a power of two; `AW = $clog2(DEPTH_WORDS)`.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_addr` in 32: fetch byte address; `i_addr[1:0]` is ignored.
- `i_data` out 32: fetched word; registered.
- `fetch_err` out 1: registered; high in the same cycle as an `i_data` produced from an out-of-range `i_addr`.
- `ld_valid` in 1: loader write request.
- `ld_ready` out 1: loader write accepted when `ld_valid & ld_ready`.
- `ld_addr` in 32: loader byte address; `[1:0]` is ignored.
- `ld_data` in 32: loader write word.
- `ld_last` in 1: marks the final word of the image; qualified by the handshake.
- `ld_cnt` out 16: number of accepted loader beats, saturating at 16'hFFFF.
- `ld_csum` out 32: running XOR of all accepted `ld_data`, including dropped beats.
- `ld_err` out 1: sticky; set by any accepted beat whose address is out of range.
- `boot_done` out 1: high in RUN.

## Operation
- States:
  - BOOT (reset state): `ld_ready`=1. Every accepted beat with an in-range address writes the array; out-of-range beats are dropped and set `ld_err`. An accepted beat with `ld_last`=1 moves the FSM to RUN on the next edge; the last beat itself is written.
  - RUN: `ld_ready`=0 and `boot_done`=1. The array is read every cycle at word index `(i_addr-BASE_ADDR)>>2`. RUN is left only by `rst`.
- Range check: an address is in range iff `addr >= BASE_ADDR` and `addr - BASE_ADDR < DEPTH_WORDS*4`. Compute the subtraction at 32 bits with no wrap-around acceptance, so an address below `BASE_ADDR` is out of range.
- Out-of-range fetch in RUN: `i_data`=32'h0000_0000 (an illegal instruction, which traps downstream) and `fetch_err`=1.
- In BOOT, `i_data`=32'h0000_0013 (NOP) and `fetch_err`=0, whatever `i_addr` is.
- `ld_cnt` and `ld_csum` update only on accepted beats. `ld_csum` is computed as `ld_csum ^ ld_data`.
- Array contents are not reset. Reads of unwritten words return undefined data; the bench must not check them.

## Timing
- Reset values: `i_data`=32'h0000_0013, `fetch_err`=0, `ld_ready`=0 during `rst`, then 1 from the first edge after `rst` deasserts. `ld_cnt`=0, `ld_csum`=0, `ld_err`=0, `boot_done`=0, state BOOT.
- Fetch latency is 1 cycle: `i_addr` is sampled at edge N, and `i_data`/`fetch_err` are valid after edge N. This gives back-to-back throughput of one word per cycle with no stall handshake; the fetch unit's `i_data_wr_en` pipeline depends on this exact one-cycle delay.
- Loader: throughput is 1 beat per cycle in BOOT. A write becomes visible to fetches after the write edge.
- Transition: the edge that accepts `ld_last` sets `boot_done`=1 and `ld_ready`=0 after that edge. The first RUN read samples `i_addr` at the following edge.
- An accepted beat with `ld_last`=1 to an out-of-range address still moves the FSM to RUN and still sets `ld_err`.
- Reset mid-load: everything returns to BOOT with counters cleared. Array contents persist but are treated as stale.
- `ld_valid` with `ld_ready`=0 has no effect, and no state changes in RUN.

## Structure
- Shared package `xrv_pkg` holds:
  - `XRV_NOP` (32'h0000_0013);
  - `XRV_ILLEGAL` (32'h0);
  - the `imem_state_e` enum {BOOT, RUN}.
- One sub-module, `xrv_sram_1rw`: a single-port array with inputs `we`, `addr[AW-1:0]`, `wdata` and a registered `rdata`. The write port is driven only in BOOT and the read port only in RUN, so no arbitration is needed.
- The FSM, range checks, counters and output muxing live in the top.

## Test plan
- Reset release: `ld_ready` goes to 1 one edge after `rst` falls; `i_data`=32'h13 and `boot_done`=0 throughout BOOT.
- Load then fetch: load 4 words 0x11111111..0x44444444 at addresses 0x0..0xC, with `ld_last` on the fourth. Expect `boot_done`=1 next edge, `ld_cnt`=4, `ld_csum`=0x44444444. Then sweep `i_addr`=0,4,8,C one per cycle; `i_data` returns 0x11111111..0x44444444 each one cycle later.
- Ignored low bits: with the image above, `i_addr`=0x6 returns 0x22222222.
- Out-of-range fetch, with `DEPTH_WORDS`=4096: `i_addr`=0x4000 gives `i_data`=0 and `fetch_err`=1 for one cycle; the next in-range address clears `fetch_err`.
- Bad load beat: a beat to `ld_addr`=0x4000 sets `ld_err` sticky, leaves the array unchanged, and counts toward `ld_cnt` and `ld_csum`.
- Reset mid-load: after 2 of 4 beats, pulse `rst`. Expect BOOT, `ld_cnt`=0, `ld_csum`=0, and `ld_ready`=0 while `rst` is high.

Source files
------------

// File: rtl/xrv_pkg.sv
// Shared xriscv definitions: canonical instruction words, the imem FSM states
// and the address range check used by the instruction-memory responder.
package xrv_pkg;

  localparam int unsigned XRV_XLEN  = 32;
  localparam int unsigned XRV_CNT_W = 16;

  localparam logic [XRV_XLEN-1:0] XRV_NOP     = 32'h0000_0013;
  localparam logic [XRV_XLEN-1:0] XRV_ILLEGAL = 32'h0000_0000;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

  // off is addr - base at 32 bits; an address below base is rejected outright
  // so a wrapped-around offset can never look in range.
  function automatic logic addr_in_range(input logic [XRV_XLEN-1:0] addr,
                                         input logic [XRV_XLEN-1:0] base,
                                         input logic [XRV_XLEN-1:0] off,
                                         input logic [XRV_XLEN:0]   span);
    return (addr >= base) && ({1'b0, off} < span);
  endfunction

endpackage

// File: rtl/xrv_sram_1rw.sv
// Single-port word array with a registered read; contents are never reset.
module xrv_sram_1rw #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/xrv_imem_resp.sv
// Instruction-memory responder: accepts a boot image over a valid/ready loader
// port, then serves one-cycle-latency fetches for the core.
module xrv_imem_resp
  import xrv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  output logic        fetch_err,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic [15:0] ld_cnt,
  output logic [31:0] ld_csum,
  output logic        ld_err,
  output logic        boot_done
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  imem_state_e state_q, state_d;

  logic                 ld_ready_q, ld_ready_d;
  logic                 boot_done_q, boot_done_d;
  logic [XRV_CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [31:0]          ld_csum_q, ld_csum_d;
  logic                 ld_err_q, ld_err_d;
  logic                 rd_run_q, rd_run_d;
  logic                 fetch_err_q, fetch_err_d;

  logic [31:0]   ld_off, i_off;
  logic          ld_ok, i_ok, ld_acc;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata;

  assign ld_off = ld_addr - BASE_ADDR;
  assign i_off  = i_addr - BASE_ADDR;
  assign ld_ok  = addr_in_range(ld_addr, BASE_ADDR, ld_off, SPAN);
  assign i_ok   = addr_in_range(i_addr, BASE_ADDR, i_off, SPAN);
  assign ld_acc = ld_valid & ld_ready_q & (state_q == BOOT);

  // Port ownership is split by state: loader writes in BOOT, fetch reads in RUN.
  assign sram_we   = ld_acc & ld_ok;
  assign sram_addr = (state_q == BOOT) ? ld_off[AW+1:2] : i_off[AW+1:2];

  xrv_sram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (ld_data),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == BOOT) && ld_acc && ld_last) begin
      state_d = RUN;
    end
  end

  always_comb begin
    ld_ready_d  = (state_d == BOOT);
    boot_done_d = (state_d == RUN);
    ld_cnt_d    = ld_cnt_q;
    ld_csum_d   = ld_csum_q;
    ld_err_d    = ld_err_q;
    rd_run_d    = (state_q == RUN);
    fetch_err_d = (state_q == RUN) & ~i_ok;
    if (ld_acc) begin
      ld_cnt_d  = (ld_cnt_q == '1) ? ld_cnt_q : ld_cnt_q + XRV_CNT_W'(1);
      ld_csum_d = ld_csum_q ^ ld_data;
      ld_err_d  = ld_err_q | ~ld_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ready_q  <= 1'b0;
      boot_done_q <= 1'b0;
      ld_cnt_q    <= '0;
      ld_csum_q   <= '0;
      ld_err_q    <= 1'b0;
      rd_run_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      ld_ready_q  <= ld_ready_d;
      boot_done_q <= boot_done_d;
      ld_cnt_q    <= ld_cnt_d;
      ld_csum_q   <= ld_csum_d;
      ld_err_q    <= ld_err_d;
      rd_run_q    <= rd_run_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Selects between flopped sources only, so fetch latency stays at one edge.
  assign i_data    = !rd_run_q   ? XRV_NOP :
                     fetch_err_q ? XRV_ILLEGAL : sram_rdata;
  assign fetch_err = fetch_err_q;
  assign ld_ready  = ld_ready_q;
  assign boot_done = boot_done_q;
  assign ld_cnt    = ld_cnt_q;
  assign ld_csum   = ld_csum_q;
  assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_xrv_imem_resp.sv
// Bench for xrv_imem_resp: directed loader/fetch vectors, fetch responses
// checked by a scoreboard monitor, status outputs checked inline.
module tb_xrv_imem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_addr = 32'h0000_4000;
  logic [31:0] i_data;
  logic        fetch_err;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = 32'h0;
  logic [31:0] ld_data = 32'h0;
  logic        ld_last = 1'b0;
  logic [15:0] ld_cnt;
  logic [31:0] ld_csum;
  logic        ld_err;
  logic        boot_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  logic fetch_vld = 1'b0;
  logic rsp_due   = 1'b0;

  xrv_imem_resp #(
    .DEPTH_WORDS (4096),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .fetch_err (fetch_err),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_cnt    (ld_cnt),
    .ld_csum   (ld_csum),
    .ld_err    (ld_err),
    .boot_done (boot_done)
  );

  always #5 clk = ~clk;

  // A fetch sampled at an edge has its response due at the following negedge.
  always @(posedge clk) rsp_due <= fetch_vld;

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rsp_due) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_underflow: response with no expectation, data=%h err=%b",
                 i_data, fetch_err);
      end else begin
        e = exp_q.pop_front();
        if (i_data !== e.data || fetch_err !== e.err) begin
          errors++;
          $display("FAIL fetch: got data=%h err=%b, expected data=%h err=%b",
                   i_data, fetch_err, e.data, e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    fetch_vld = 1'b1;
    i_addr    = a;
    exp_q.push_back(r);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    repeat (2) tick();
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("rst_i_data", i_data, 32'h0000_0013);
    chk("rst_fetch_err", 32'(fetch_err), 32'h0);
    chk("rst_boot_done", 32'(boot_done), 32'h0);
    chk("rst_ld_cnt", 32'(ld_cnt), 32'h0);
    chk("rst_ld_csum", ld_csum, 32'h0);
    chk("rst_ld_err", 32'(ld_err), 32'h0);

    rst = 1'b0;
    chk("rel_ld_ready_pre_edge", 32'(ld_ready), 32'h0);
    tick();
    chk("rel_ld_ready", 32'(ld_ready), 32'h1);

    // Partial load interrupted by reset.
    beat(32'h0, 32'hCAFE_0000, 1'b0);
    beat(32'h4, 32'hCAFE_0001, 1'b0);
    chk("mid_ld_cnt", 32'(ld_cnt), 32'd2);
    chk("mid_ld_csum", ld_csum, 32'h0000_0001);
    rst = 1'b1;
    #1;
    chk("mid_rst_ld_cnt", 32'(ld_cnt), 32'h0);
    chk("mid_rst_ld_csum", ld_csum, 32'h0);
    chk("mid_rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("mid_rst_boot_done", 32'(boot_done), 32'h0);
    tick();
    chk("mid_rst_ld_ready_held", 32'(ld_ready), 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_rel_ld_ready", 32'(ld_ready), 32'h1);
    chk("mid_rel_ld_cnt", 32'(ld_cnt), 32'h0);

    // Full image with one out-of-range beat before the last word.
    beat(32'h0, 32'h1111_1111, 1'b0);
    beat(32'h4, 32'h2222_2222, 1'b0);
    beat(32'h8, 32'h3333_3333, 1'b0);
    chk("load3_ld_cnt", 32'(ld_cnt), 32'd3);
    chk("load3_ld_csum", ld_csum, 32'h0);
    chk("load3_ld_err", 32'(ld_err), 32'h0);
    chk("boot_i_data", i_data, 32'h0000_0013);
    chk("boot_fetch_err", 32'(fetch_err), 32'h0);
    beat(32'h4000, 32'hAAAA_AAAA, 1'b0);
    chk("bad_ld_err", 32'(ld_err), 32'h1);
    chk("bad_ld_cnt", 32'(ld_cnt), 32'd4);
    chk("bad_ld_csum", ld_csum, 32'hAAAA_AAAA);
    chk("bad_boot_done", 32'(boot_done), 32'h0);

    ld_valid = 1'b1;
    ld_addr  = 32'hC;
    ld_data  = 32'h4444_4444;
    ld_last  = 1'b1;
    tick();
    // Keep requesting in RUN; nothing may be accepted.
    ld_addr = 32'h0;
    ld_data = 32'h5555_5555;
    ld_last = 1'b0;
    chk("run_boot_done", 32'(boot_done), 32'h1);
    chk("run_ld_ready", 32'(ld_ready), 32'h0);
    chk("run_ld_cnt", 32'(ld_cnt), 32'd5);
    chk("run_ld_csum", ld_csum, 32'hEEEE_EEEE);
    chk("run_ld_err", 32'(ld_err), 32'h1);
    chk("run_first_i_data", i_data, 32'h0000_0013);
    repeat (2) tick();
    chk("run_ignore_ld_cnt", 32'(ld_cnt), 32'd5);
    chk("run_ignore_ld_csum", ld_csum, 32'hEEEE_EEEE);
    ld_valid = 1'b0;

    fetch(32'h0000_0000, 32'h1111_1111, 1'b0);
    fetch(32'h0000_0004, 32'h2222_2222, 1'b0);
    fetch(32'h0000_0008, 32'h3333_3333, 1'b0);
    fetch(32'h0000_000C, 32'h4444_4444, 1'b0);
    fetch(32'h0000_0006, 32'h2222_2222, 1'b0);
    fetch(32'h0000_4000, 32'h0000_0000, 1'b1);
    fetch(32'h0000_0000, 32'h1111_1111, 1'b0);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
    fetch(32'h0000_0003, 32'h1111_1111, 1'b0);
    fetch_vld = 1'b0;
    repeat (2) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("end_boot_done", 32'(boot_done), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
